pmod_8led2_pattern: RTL
=======================

# pmod_8led2_pattern

Parametrised successor to the single-mode PMOD 8LED2 counter demo. It drives one dual-colour PMOD LED bank (green and red rails) from one system clock. An internal divider produces a tick at `TICK_HZ`; on each tick the green pattern advances in a selectable mode (binary up, binary down, Gray, bounce scan). The red rail carries a heartbeat and a wrap indicator. It sits directly behind the PMOD pins in the iCEBreaker and DE0-Nano example designs.

## Interface
- `CLK_HZ`, 12000000, input clock frequency in Hz.
- `TICK_HZ`, 2, tick rate; `DIV = CLK_HZ/TICK_HZ` (integer).
  - Elaboration error if `DIV < 2` or `CLK_HZ % TICK_HZ != 0`.
- `WIDTH`, 8, LEDs per colour (≥3).
  - `N = WIDTH-1` pattern bits.
  - Bit 0 = LED D1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable.
  - Low freezes the divider, pattern, heartbeat and wrap flag.
- `clr`  in  1  synchronous clear.
- `mode`  in  2  pattern mode: 0 UP, 1 DOWN, 2 GRAY, 3 SCAN.
- `ledg`  out  WIDTH  green rail.
  - `ledg[0]` is always 0.
  - `ledg[WIDTH-1:1]` is the pattern.
- `ledr`  out  WIDTH  red rail.
  - `ledr[0]` is the heartbeat.
  - `ledr[1]` is the wrap flag.
  - All other bits are always 0.

## Operation
- **Divider:**
  - `div_cnt` counts 0..DIV-1 while `en=1`, then returns to 0.
  - `tick` is high in the cycle `div_cnt==DIV-1`.
  - When `en=0`, `div_cnt` holds its value.
- **Active mode register `act_mode`:** `mode` is sampled only on a tick.
  - If `mode != act_mode`: `act_mode <= mode`, the pattern loads that mode's initial value, and no step occurs.
- **Initial values:**
  - UP: 0.
  - DOWN: all ones.
  - GRAY: internal count 0.
  - SCAN: one-hot bit 0, direction up.
- **Step on tick (same mode):**
  - UP: `cnt+1` mod 2^N.
  - DOWN: `cnt-1` mod 2^N.
  - GRAY: internal `cnt+1`; displayed value is `cnt ^ (cnt>>1)`.
  - SCAN: the one-hot bit shifts toward the current direction. The direction reverses on reaching bit N-1 or bit 0, so each end is lit once per pass. The period is 2N-2 ticks.
- **Heartbeat:** toggles on every tick, giving a square wave at TICK_HZ/2.
- **Wrap flag:** set on the tick that performs a wrap and cleared on the next tick, so it is high for one tick period. A wrap is any of:
  - UP or GRAY: internal count all ones → 0.
  - DOWN: 0 → all ones.
  - SCAN: a step that lands on bit N-1 or bit 0.
  - A mode-change load is never a wrap.
- **Clear (`clr=1`):**
  - `div_cnt <= 0`.
  - Pattern loads the initial value for the current `mode`, and `act_mode <= mode`.
  - Heartbeat and wrap flag go to 0.
  - `clr` overrides `tick` and `en`.
- **Reset values:**
  - `div_cnt = 0`, `act_mode = UP`, count 0, SCAN direction up.
  - `ledg = 0`, `ledr = 0`.

## Timing
- All outputs come directly from registers with no combinational path from inputs.
- State updates on the rising edge at the end of the tick cycle, so outputs change one cycle after `tick` asserts.
- First tick after `rst_n` rises with `en=1`: outputs first change DIV cycles after the first active edge.
- Tick spacing is exactly DIV cycles while `en=1`.
  - `en` low for k cycles delays the next tick by exactly k cycles.
- `clr` takes effect at the next edge. The following tick occurs DIV cycles later.
- `rst_n` asserted mid-count forces all reset values immediately, without waiting for a clock edge.
- A `mode` change between ticks has no visible effect until the next tick.

## Structure
- **Package `pmod_led_pkg`:**
  - `led_mode_t` enum: UP=0, DOWN=1, GRAY=2, SCAN=3.
  - `DIV` computation function.
  - Initial-value function per mode, parametrised by N.
- **Sub-module `pmod_tick_gen`** (`DIV` parameter; `clk`, `rst_n`, `en`, `clr` in; `tick` out). Reusable by the other PMOD examples.
- **Top:**
  - Pattern register and SCAN direction bit.
  - Mode register.
  - Heartbeat and wrap registers.
  - Gray encode as the output-register input.

## Test plan
Bench parameters: CLK_HZ=8, TICK_HZ=2 (DIV=4), WIDTH=8 (N=7).

- **UP from reset:** release `rst_n`, `en=1`, `mode=0`.
  - Ticks every 4 cycles.
  - `ledg[7:1]` steps 0,1,2…
  - `ledr[0]` toggles each tick.
  - After tick 128, `ledg[7:1]=0` and `ledr[1]=1` for 4 cycles.
- **Mode change to DOWN:** switch `mode=1` mid-tick.
  - Pattern unchanged until the next tick, then 7'h7F with no wrap flag.
  - Following ticks give 7E, 7D…
  - 00→7F sets `ledr[1]`.
- **GRAY:** `mode=2` from clear.
  - Display sequence 00,01,03,02,06,07,05,04.
  - Exactly one bit changes per tick.
- **SCAN:** `mode=3`.
  - One-hot sequence 01,02,04,…,40,20,…,01 with a period of 12 ticks.
  - `ledr[1]` pulses on reaching 40 and on reaching 01.
- **Enable, clear, async reset:**
  - Drop `en` for 5 cycles mid-count: the next tick is delayed 5 cycles and no output changes meanwhile.
  - `clr` pulse: all outputs 0 next cycle (UP mode), and the next tick is 4 cycles later.
  - Assert `rst_n` low between edges: outputs go to 0 without a clock edge.

Source files
------------

// File: rtl/pmod_led_pkg.sv
// Shared types and helpers for the PMOD LED examples: pattern modes,
// divider computation and per-mode initial pattern values.
package pmod_led_pkg;

  typedef enum logic [1:0] {
    UP   = 2'd0,
    DOWN = 2'd1,
    GRAY = 2'd2,
    SCAN = 2'd3
  } led_mode_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Returned 32 bits wide; callers keep the low n bits.
  function automatic logic [31:0] init_value(input led_mode_t m, input int n);
    case (m)
      DOWN:    return (32'd1 << n) - 32'd1;
      SCAN:    return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/pmod_tick_gen.sv
// Free-running tick divider: one-cycle tick every DIV enabled cycles,
// frozen while en is low, restarted by a synchronous clear.
module pmod_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Gated by en so a count parked on LAST cannot fire while frozen.
  assign tick = en && (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pmod_8led2_pattern.sv
// Dual-colour PMOD LED bank driver: green rail shows a mode-selectable
// pattern stepped at TICK_HZ, red rail carries heartbeat and wrap flag.
module pmod_8led2_pattern
  import pmod_led_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 2,
  parameter int WIDTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] ledg,
  output logic [WIDTH-1:0] ledr
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int N   = WIDTH - 1;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || WIDTH < 3) begin : g_bad_params
    $error("pmod_8led2_pattern: invalid CLK_HZ/TICK_HZ/WIDTH combination");
  end

  logic tick;

  pmod_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .tick  (tick)
  );

  led_mode_t     act_q, act_d, req_mode;
  logic [N-1:0]  cnt_q, cnt_d, cnt_init, pat_q, pat_d;
  logic [31:0]   init_full;
  logic          dir_q, dir_d;
  logic          hb_q, hb_d;
  logic          wrap_q, wrap_d;

  // cnt holds the binary count for UP/DOWN/GRAY and the one-hot for SCAN.
  always_comb begin
    req_mode  = led_mode_t'(mode);
    init_full = init_value(req_mode, N);
    cnt_init  = init_full[N-1:0];
    act_d     = act_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    hb_d      = hb_q;
    wrap_d    = wrap_q;

    if (clr) begin
      act_d  = req_mode;
      cnt_d  = cnt_init;
      dir_d  = 1'b1;
      hb_d   = 1'b0;
      wrap_d = 1'b0;
    end else if (tick) begin
      hb_d   = ~hb_q;
      wrap_d = 1'b0;
      if (req_mode != act_q) begin
        act_d = req_mode;
        cnt_d = cnt_init;
        dir_d = 1'b1;
      end else begin
        unique case (act_q)
          UP, GRAY: begin
            cnt_d  = cnt_q + N'(1);
            wrap_d = &cnt_q;
          end
          DOWN: begin
            cnt_d  = cnt_q - N'(1);
            wrap_d = ~|cnt_q;
          end
          SCAN: begin
            if (dir_q) begin
              cnt_d = cnt_q << 1;
              if (cnt_d[N-1]) begin
                dir_d  = 1'b0;
                wrap_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q >> 1;
              if (cnt_d[0]) begin
                dir_d  = 1'b1;
                wrap_d = 1'b1;
              end
            end
          end
        endcase
      end
    end

    pat_d = (act_d == GRAY) ? (cnt_d ^ (cnt_d >> 1)) : cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= UP;
      cnt_q  <= '0;
      dir_q  <= 1'b1;
      hb_q   <= 1'b0;
      wrap_q <= 1'b0;
      pat_q  <= '0;
    end else begin
      act_q  <= act_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      hb_q   <= hb_d;
      wrap_q <= wrap_d;
      pat_q  <= pat_d;
    end
  end

  assign ledg = {pat_q, 1'b0};
  assign ledr = {{(WIDTH-2){1'b0}}, wrap_q, hb_q};

endmodule
